// File: rtl/future_pkg.sv
// Shared GF(2^4) definitions for the FUTURE MixColumns datapath.
// Field is GF(2^4) mod x^4+x+1; the matrix is stored row-major, one nibble per entry.
package future_pkg;

  typedef logic [3:0] nib_t;

  // x^4 folds back to x+1
  localparam nib_t GF_RED = 4'h3;

  // Entry (row i, col j) lives at nibble 4*i+j, so row 0 is the least significant 16 bits.
  localparam logic [63:0] MIX_M = 64'h1899_9832_9923_8198;

  function automatic nib_t gf_xtime(input nib_t v);
    return {v[2:0], 1'b0} ^ (v[3] ? GF_RED : 4'h0);
  endfunction

  function automatic nib_t mix_coef(input int row, input int col);
    return MIX_M[(4*row+col)*4 +: 4];
  endfunction

endpackage

// File: rtl/future_gf16_mulc.sv
// Combinational multiply of a nibble by a fixed GF(2^4) constant.
// Only the coefficients that appear in the FUTURE matrix are supported.
module future_gf16_mulc
  import future_pkg::*;
#(
  parameter nib_t COEF = 4'h1
) (
  input  nib_t a,
  output nib_t p
);

  nib_t x2;
  nib_t x4;
  nib_t x8;

  always_comb begin
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    case (COEF)
      4'h1:    p = a;
      4'h2:    p = x2;
      4'h3:    p = x2 ^ a;
      4'h8:    p = x8;
      4'h9:    p = x8 ^ a;
      default: p = 4'h0;
    endcase
  end

endmodule

// File: rtl/future_mixcolumn.sv
// Single-column FUTURE MixColumns: 4x4 constant matrix over GF(2^4),
// combinational product tree feeding a registered output (1-cycle latency).
module future_mixcolumn
  import future_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] c
);

  nib_t        prod [4][4];
  logic [15:0] y;
  logic [15:0] c_d;
  logic [15:0] c_q;
  logic        out_valid_d;
  logic        out_valid_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_col
      future_gf16_mulc #(
        .COEF(mix_coef(gi, gj))
      ) u_mul (
        .a(b[4*gj +: 4]),
        .p(prod[gi][gj])
      );
    end
    assign y[4*gi +: 4] = prod[gi][0] ^ prod[gi][1] ^ prod[gi][2] ^ prod[gi][3];
  end

  always_comb begin
    c_d         = c_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      c_d = y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_future_mixcolumn.sv
// Scoreboard bench for future_mixcolumn: directed vectors, async reset, bubbles,
// and random columns with a linearity cross-check.
module tb_future_mixcolumn;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] c;

  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] prev_c   = 16'h0000;

  future_mixcolumn dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .b(b),
    .out_valid(out_valid),
    .c(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: schoolbook polynomial multiply then reduce by x^4+x+1.
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] k);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++)
      if (k[i]) p = p ^ ({4'h0, a} << i);
    for (int i = 7; i >= 4; i--)
      if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [15:0] ref_mix(input logic [15:0] v);
    logic [3:0] m [4][4];
    logic [15:0] r;
    m = '{'{4'h8, 4'h9, 4'h1, 4'h8},
          '{4'h3, 4'h2, 4'h9, 4'h9},
          '{4'h2, 4'h3, 4'h8, 4'h9},
          '{4'h9, 4'h9, 4'h8, 4'h1}};
    r = 16'h0000;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[4*i +: 4] = r[4*i +: 4] ^ ref_mul(v[4*j +: 4], m[i][j]);
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic [15:0] e);
    @(negedge clk);
    b        = v;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor: one line per observed transaction, decoupled from the driver.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_c = 16'h0000;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got c=%h with out_valid=1, expected no output", c);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("result", c, e);
        $display("txn c=%h expected=%h", c, e);
      end
      prev_c = c;
    end else begin
      check("hold_on_bubble", c, prev_c);
    end
  end

  initial begin
    logic [15:0] x, y;
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    b        = 16'h0000;
    #2;
    check("reset_c", c, 16'h0000);
    check("reset_valid", {15'h0, out_valid}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, hand-computed
    send(16'h0001, 16'h9238);
    send(16'h0010, 16'h9329);
    send(16'h0002, 16'h1463);
    idle();
    send(16'h1111, 16'h9018);
    idle();
    idle();
    send(16'h0001, 16'h9238);
    send(16'h0010, 16'h9329);
    send(16'h1111, 16'h9018);
    idle();
    send(16'h0000, 16'h0000);
    idle();

    // Async reset with a valid column pending at the input
    send(16'h0002, 16'h1463);
    @(negedge clk);
    b        = 16'hFFFF;
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_reset_c", c, 16'h0000);
    check("async_reset_valid", {15'h0, out_valid}, 16'h0000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold_c", c, 16'h0000);
      check("reset_hold_valid", {15'h0, out_valid}, 16'h0000);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle();
    send(16'h0010, 16'h9329);
    idle();

    // Random columns plus linearity: f(x^y) must equal f(x)^f(y)
    for (int i = 0; i < 340; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      send(x, ref_mix(x));
      send(y, ref_mix(y));
      send(x ^ y, ref_mix(x) ^ ref_mix(y));
      if (i % 17 == 0) idle();
    end
    idle();

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
